// File: rtl/enc_index_seq_if.sv
// Control/status and encoder-side signals of the index-search sequencer.
// master = controller/encoder side, slave = the sequencer itself.
interface enc_index_seq_if #(
  parameter int BITS    = 32,
  parameter int TO_BITS = 24
);
  logic                      arm;
  logic                      abort;
  logic [TO_BITS-1:0]        timeout_cycles;
  logic                      indexout;
  logic signed [BITS-1:0]    position;
  logic                      indexenable;
  logic                      busy;
  logic                      done;
  logic                      timed_out;
  logic                      aborted;
  logic signed [BITS-1:0]    index_pos;
  logic [15:0]               index_cnt;

  modport master (
    output arm, abort, timeout_cycles, indexout, position,
    input  indexenable, busy, done, timed_out, aborted, index_pos, index_cnt
  );

  modport slave (
    input  arm, abort, timeout_cycles, indexout, position,
    output indexenable, busy, done, timed_out, aborted, index_pos, index_cnt
  );
endinterface

// File: rtl/enc_index_seq.sv
// Encoder index-search sequencer: enables the counter's index latch, waits for
// the index to zero the count, captures the pre-zero position, then releases.
module enc_index_seq #(
  parameter int BITS       = 32,
  parameter int TO_BITS    = 24,
  parameter int REL_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  enc_index_seq_if.slave bus
);
  localparam int RW = $clog2(REL_CYCLES + 1);

  if (REL_CYCLES < 2) begin : g_bad_rel
    $error("REL_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, ARMING, WAIT_INDEX, RELEASE} state_t;

  state_t                 state_q;
  logic                   indexenable_q;
  logic                   done_q;
  logic                   timed_out_q;
  logic                   aborted_q;
  logic signed [BITS-1:0] index_pos_q;
  logic [15:0]            index_cnt_q;
  logic [TO_BITS-1:0]     timer_q;
  logic signed [BITS-1:0] pos_q;
  logic                   idx_q;
  logic [RW-1:0]          rel_cnt_q;

  logic                   idx_edge;
  logic                   capture;
  logic                   timeout_hit;
  logic [TO_BITS-1:0]     timer_d;

  always_comb begin
    idx_edge    = idx_q & ~bus.indexout;
    capture     = (state_q == WAIT_INDEX) && idx_edge;
    timeout_hit = (bus.timeout_cycles != '0) &&
                  (timer_q == bus.timeout_cycles - TO_BITS'(1));
    // Saturate so a disabled timeout never wraps into a false match later.
    timer_d     = (timer_q == '1) ? timer_q : timer_q + TO_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      indexenable_q <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      aborted_q     <= 1'b0;
      index_pos_q   <= '0;
      index_cnt_q   <= '0;
      timer_q       <= '0;
      pos_q         <= '0;
      idx_q         <= 1'b0;
      rel_cnt_q     <= '0;
    end else begin
      // The encoder zeroes its count in the same cycle indexout falls, so the
      // one-cycle-old position is the value to capture.
      pos_q       <= bus.position;
      idx_q       <= bus.indexout;
      done_q      <= 1'b0;
      index_cnt_q <= index_cnt_q + 16'(capture);

      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_q       <= ARMING;
            indexenable_q <= 1'b1;
            timed_out_q   <= 1'b0;
            aborted_q     <= 1'b0;
            timer_q       <= '0;
          end
        end

        ARMING: begin
          if (bus.abort) begin
            aborted_q     <= 1'b1;
            state_q       <= RELEASE;
            indexenable_q <= 1'b0;
            rel_cnt_q     <= '0;
          end else if (timeout_hit) begin
            timed_out_q   <= 1'b1;
            state_q       <= RELEASE;
            indexenable_q <= 1'b0;
            rel_cnt_q     <= '0;
          end else if (bus.indexout) begin
            state_q <= WAIT_INDEX;
            timer_q <= '0;
          end else begin
            timer_q <= timer_d;
          end
        end

        WAIT_INDEX: begin
          // Index edge wins over abort, abort wins over timeout.
          if (idx_edge) begin
            index_pos_q   <= pos_q;
            done_q        <= 1'b1;
            state_q       <= RELEASE;
            indexenable_q <= 1'b0;
            rel_cnt_q     <= '0;
          end else if (bus.abort) begin
            aborted_q     <= 1'b1;
            state_q       <= RELEASE;
            indexenable_q <= 1'b0;
            rel_cnt_q     <= '0;
          end else if (timeout_hit) begin
            timed_out_q   <= 1'b1;
            state_q       <= RELEASE;
            indexenable_q <= 1'b0;
            rel_cnt_q     <= '0;
          end else begin
            timer_q <= timer_d;
          end
        end

        RELEASE: begin
          // Hold the enable low long enough for the encoder's latch to clear.
          if (rel_cnt_q == RW'(REL_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            rel_cnt_q <= rel_cnt_q + RW'(1);
          end
        end

        default: begin
          state_q       <= IDLE;
          indexenable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.indexenable = indexenable_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.aborted     = aborted_q;
  assign bus.index_pos   = index_pos_q;
  assign bus.index_cnt   = index_cnt_q;
endmodule

// File: tb/tb_enc_index_seq.sv
// Directed bench for enc_index_seq: stimulus pushes expected search outcomes,
// a negedge monitor pops and compares them whenever a search ends.
module tb_enc_index_seq;
  localparam int BITS    = 32;
  localparam int TO_BITS = 24;
  localparam int REL     = 4;

  localparam logic [2:0] EV_DONE = 3'b100;
  localparam logic [2:0] EV_TO   = 3'b010;
  localparam logic [2:0] EV_AB   = 3'b001;

  typedef struct {
    logic [2:0]  flags;
    longint      pos;
    logic [15:0] cnt;
  } evt_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  evt_t exp_q[$];

  always #5 clk = ~clk;

  enc_index_seq_if #(.BITS(BITS), .TO_BITS(TO_BITS)) bus ();

  enc_index_seq #(.BITS(BITS), .TO_BITS(TO_BITS), .REL_CYCLES(REL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_evt(input logic [2:0] flags, input longint pos,
                                   input logic [15:0] cnt);
    evt_t e;
    e.flags = flags;
    e.pos   = pos;
    e.cnt   = cnt;
    exp_q.push_back(e);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_bound", longint'(bus.busy), 0);
  endtask

  // Monitor: a search ends on a done pulse or a rising sticky flag.
  initial begin
    logic prev_to = 1'b0;
    logic prev_ab = 1'b0;
    logic rel_active = 1'b0;
    int   rel_count = 0;
    logic ev;
    evt_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_to    = 1'b0;
        prev_ab    = 1'b0;
        rel_active = 1'b0;
      end else begin
        if (rel_active) begin
          if (bus.busy) rel_count++;
          else begin
            check("release_len", rel_count, REL);
            rel_active = 1'b0;
          end
        end
        ev = bus.done || (bus.timed_out && !prev_to) || (bus.aborted && !prev_ab);
        if (ev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_evt", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] txn flags=%b index_pos=%0d index_cnt=%0d (exp %b/%0d/%0d)",
                     {bus.done, bus.timed_out, bus.aborted}, bus.index_pos,
                     bus.index_cnt, e.flags, e.pos, e.cnt);
            check("evt_flags", longint'({bus.done, bus.timed_out, bus.aborted}),
                  longint'(e.flags));
            check("evt_index_pos", longint'(bus.index_pos), e.pos);
            check("evt_index_cnt", longint'(bus.index_cnt), longint'(e.cnt));
            check("evt_indexenable", longint'(bus.indexenable), 0);
          end
          rel_active = 1'b1;
          rel_count  = bus.busy ? 1 : 0;
        end
        prev_to = bus.timed_out;
        prev_ab = bus.aborted;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset              = 1'b1;
    bus.arm            = 1'b0;
    bus.abort          = 1'b0;
    bus.timeout_cycles = '0;
    bus.indexout       = 1'b0;
    bus.position       = '0;
    repeat (3) tick();

    check("rst_indexenable", longint'(bus.indexenable), 0);
    check("rst_busy",        longint'(bus.busy), 0);
    check("rst_done",        longint'(bus.done), 0);
    check("rst_timed_out",   longint'(bus.timed_out), 0);
    check("rst_aborted",     longint'(bus.aborted), 0);
    check("rst_index_pos",   longint'(bus.index_pos), 0);
    check("rst_index_cnt",   longint'(bus.index_cnt), 0);
    reset = 1'b0;
    tick();

    // Normal search: capture 1234 just before the encoder zeroes the count.
    push_evt(EV_DONE, 1234, 16'd1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("arm_latency", longint'(bus.indexenable), 1);
    repeat (3) tick();
    bus.indexout = 1'b1;
    for (int p = 1230; p <= 1234; p++) begin
      bus.position = p;
      tick();
    end
    bus.position = 0;
    bus.indexout = 1'b0;
    tick();
    wait_idle();

    // Timeout of 10 while in ARMING; indexout falls during ARMING (ignored).
    bus.timeout_cycles = 10;
    bus.indexout       = 1'b1;
    bus.position       = 555;
    push_evt(EV_TO, 1234, 16'd1);
    bus.arm = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.indexout = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.timed_out && n < 50);
    check("timeout_latency", n, 10);
    wait_idle();
    bus.timeout_cycles = 0;

    // Abort after 5 cycles in WAIT_INDEX; re-arm clears timed_out.
    push_evt(EV_AB, 1234, 16'd1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("arm_clears_to", longint'(bus.timed_out), 0);
    bus.indexout = 1'b1;
    bus.position = 77;
    tick();
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_idle();
    bus.indexout = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle_busy", longint'(bus.busy), 0);
    check("abort_sticky", longint'(bus.aborted), 1);

    // Index edge and abort in the same cycle: capture wins; arm while busy ignored.
    push_evt(EV_DONE, 502, 16'd2);
    bus.arm = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.indexout = 1'b1;
    bus.position = 500;
    tick();
    bus.position = 501;
    bus.arm      = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.position = 502;
    tick();
    bus.position = 0;
    bus.indexout = 1'b0;
    bus.abort    = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_idle();

    // Reset in WAIT_INDEX drops everything on the next cycle.
    bus.arm = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.indexout = 1'b1;
    bus.position = 900;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_indexenable", longint'(bus.indexenable), 0);
    check("mid_rst_busy",        longint'(bus.busy), 0);
    check("mid_rst_index_pos",   longint'(bus.index_pos), 0);
    check("mid_rst_index_cnt",   longint'(bus.index_cnt), 0);
    check("mid_rst_done",        longint'(bus.done), 0);
    reset        = 1'b0;
    bus.indexout = 1'b0;
    tick();

    // Clean search after reset, negative position.
    push_evt(EV_DONE, -42, 16'd1);
    bus.arm = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.indexout = 1'b1;
    bus.position = -42;
    tick();
    tick();
    bus.position = 0;
    bus.indexout = 1'b0;
    tick();
    wait_idle();

    // Long wait with timeout disabled; counter preloaded to wrap.
    force dut.index_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.index_cnt_q;
    tick();
    check("cnt_preload", longint'(bus.index_cnt), 65535);
    push_evt(EV_DONE, 2999, 16'd0);
    bus.arm = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.indexout = 1'b1;
    for (int p = 0; p < 3000; p++) begin
      bus.position = p;
      tick();
    end
    bus.position = 0;
    bus.indexout = 1'b0;
    tick();
    wait_idle();

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
